// File: rtl/count_stream_decoder.sv
// Receive-side decoder/checker for a 4-bit up/down counter stream.
// Optional hold-run stall detector: define COUNT_STREAM_DECODER_STALL_DET_EN.
module count_stream_decoder #(
  parameter int POS_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int STALL_CYCLES  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_en,
  input  logic [3:0]               count_in,
  input  logic                     carry_in,
  output logic                     primed,
  output logic                     step_up,
  output logic                     step_down,
  output logic                     holding,
  output logic                     wrap_up,
  output logic                     wrap_down,
  output logic                     seq_error,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [POS_WIDTH-1:0]     position,
  output logic                     stalled
);

  typedef enum logic {UNPRIMED, TRACK} state_t;

  state_t                   state, state_next;
  logic [3:0]               prev, prev_next;
  logic [3:0]               delta;
  logic                     is_up, is_down, is_hold, at_max, at_min;
  logic                     track_sample;
  logic                     step_up_next, step_down_next, holding_next;
  logic                     wrap_up_next, wrap_down_next, seq_error_next;
  logic [ERR_CNT_WIDTH-1:0] err_count_next;
  logic [POS_WIDTH-1:0]     position_next;

  assign primed       = (state == TRACK);
  assign track_sample = sample_en && (state == TRACK);
  assign delta        = count_in - prev;
  assign is_up        = (delta == 4'd1);
  assign is_down      = (delta == 4'hF);
  assign is_hold      = (delta == 4'd0);
  assign at_max       = (prev == 4'hF);
  assign at_min       = (prev == 4'd0);

  always_comb begin
    state_next     = state;
    prev_next      = prev;
    step_up_next   = 1'b0;
    step_down_next = 1'b0;
    wrap_up_next   = 1'b0;
    wrap_down_next = 1'b0;
    seq_error_next = 1'b0;
    holding_next   = holding;
    err_count_next = err_count;
    position_next  = position;
    if (sample_en) begin
      prev_next = count_in;
      case (state)
        UNPRIMED: state_next = TRACK;
        TRACK: begin
          holding_next   = is_hold;
          step_up_next   = is_up;
          step_down_next = is_down;
          wrap_up_next   = is_up && at_max;
          wrap_down_next = is_down && at_min;
          // Illegal delta and carry mismatch merge into one error event.
          seq_error_next = !(is_up || is_down || is_hold) ||
                           (carry_in != ((is_up && at_max) || (is_down && at_min)));
          if (seq_error_next && (err_count != '1))
            err_count_next = err_count + ERR_CNT_WIDTH'(1);
          if (is_up)
            position_next = position + POS_WIDTH'(1);
          else if (is_down)
            position_next = position - POS_WIDTH'(1);
        end
        default: state_next = UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNPRIMED;
      prev      <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      holding   <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      seq_error <= 1'b0;
      err_count <= '0;
      position  <= '0;
    end else begin
      state     <= state_next;
      prev      <= prev_next;
      step_up   <= step_up_next;
      step_down <= step_down_next;
      holding   <= holding_next;
      wrap_up   <= wrap_up_next;
      wrap_down <= wrap_down_next;
      seq_error <= seq_error_next;
      err_count <= err_count_next;
      position  <= position_next;
    end
  end

`ifdef COUNT_STREAM_DECODER_STALL_DET_EN
  localparam int RUN_W = $clog2(STALL_CYCLES + 1);

  logic [RUN_W-1:0] run, run_next;
  logic             stalled_next;

  // Run counter parks at STALL_CYCLES so a long hold cannot wrap it.
  always_comb begin
    run_next     = run;
    stalled_next = stalled;
    if (track_sample) begin
      if (is_hold) begin
        if (run != RUN_W'(STALL_CYCLES))
          run_next = run + RUN_W'(1);
        stalled_next = (run_next == RUN_W'(STALL_CYCLES));
      end else begin
        run_next     = '0;
        stalled_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= '0;
      stalled <= 1'b0;
    end else begin
      run     <= run_next;
      stalled <= stalled_next;
    end
  end
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: doc/count_stream_decoder.md
Name: count_stream_decoder

Overview:
- Receive-side companion of the 4-bit up/down counter.
- Samples the counter's `count[3:0]` and `carry_out` every enabled cycle and recovers the step type (hold, up or down).
- Flags wrap events, keeps an extended signed position and detects illegal sequences such as jumps or a bad carry.
- Sits beside the counter as an on-chip consumer and checker.

Parameters:
- POS_WIDTH, 16, width of the signed extended position accumulator.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- STALL_CYCLES, 8, consecutive hold samples before `stalled` asserts (optional feature only).

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous active-low reset
- sample_en  in  1  sample the inputs this cycle
- count_in  in  4  counter value under observation
- carry_in  in  1  counter carry_out
- primed  out  1  a reference value has been captured
- step_up  out  1  pulse: last sample was +1
- step_down  out  1  pulse: last sample was -1
- holding  out  1  level: last sample equalled the previous one
- wrap_up  out  1  pulse: 15->0 observed
- wrap_down  out  1  pulse: 0->15 observed
- seq_error  out  1  pulse: illegal delta or carry mismatch
- err_count  out  ERR_CNT_WIDTH  saturating count of seq_error events
- position  out  POS_WIDTH  signed accumulated steps since priming
- stalled  out  1  hold run reached STALL_CYCLES (0 when the feature is absent)

Behaviour:
- Reset (async assert, sync release) sets every output to 0, `prev` to 0 and the FSM to UNPRIMED.
- FSM states are UNPRIMED and TRACK.
  - UNPRIMED: the first cycle with `sample_en`=1 loads `prev`<=`count_in`, sets `primed`=1 and moves to TRACK. No classification happens and `carry_in` is ignored on this sample.
  - TRACK: on each cycle with `sample_en`=1, compute `d = (count_in - prev) mod 16`:
    - d=0: `holding`=1, `position` unchanged.
    - d=1: `step_up`=1, `position`+1; if `prev`=15, `wrap_up`=1.
    - d=15: `step_down`=1, `position`-1; if `prev`=0, `wrap_down`=1.
    - any other d: `seq_error`=1, `position` unchanged, `holding`/`step` flags 0.
    - Every sample then loads `prev`<=`count_in` (resync after a jump).
  - Carry rule: `carry_in` must be 1 exactly on samples with `wrap_up` or `wrap_down`, and 0 otherwise.
    - A mismatch raises `seq_error`.
    - The step classification and position update still apply.
    - Carry mismatch and illegal delta together produce a single `seq_error` pulse and a single `err_count` increment.
- `sample_en`=0 cycles: all pulse outputs are 0, `holding` keeps its value, and nothing else changes. `sample_en` gaps do not unprime the block.
- Latency: outputs are registered and reflect the sample taken on the previous rising edge (1 cycle).
- `position` is two's complement and wraps silently at POS_WIDTH (32767+1 -> -32768).
- `err_count` increments on each `seq_error` and saturates at all-ones.
- Asserting reset mid-stream clears everything; the next enabled sample primes again.

Optional Feature:
- Macro: COUNT_STREAM_DECODER_STALL_DET_EN.
- When defined:
  - A hold-run counter increments on each enabled d=0 sample and clears on any non-hold enabled sample.
  - `stalled` is a level that asserts on the sample where the run reaches STALL_CYCLES and holds until the next non-hold sample or reset.
  - `sample_en`=0 cycles neither advance nor clear the run.
- When undefined: no run counter is built and `stalled` is tied to 0.

Test Plan:
- Reset low, then release; `sample_en`=1 with `count_in`=0, 1, 2 -> `primed`=1 after the first sample, `step_up` pulses twice, `position`=2, `err_count`=0.
- Count 14, 15, 0 with `carry_in`=1 only on the 0 sample -> `wrap_up`=1 on the 15->0 sample, no `seq_error`, `position` advances by 2.
- After priming at 1, count 1, 0, 15 with `carry_in`=1 only on the 15 sample -> `step_down` twice, `wrap_down` on 0->15, `position`=-2.
- Count 3 then 7 -> `seq_error`=1, `err_count`=1, `position` unchanged. A following 8 -> `step_up` with no error (resync).
- Count 5 then 6 with `carry_in`=1 -> `step_up`=1 and `seq_error`=1. Separately, force 300 errors -> `err_count` saturates at 255.
- Feature on, STALL_CYCLES=8, count held at 9 for 8 enabled samples with `sample_en`=0 gaps interleaved -> `stalled` rises on the 8th hold sample. Next sample 10 -> `stalled`=0. Reset mid-run -> all outputs 0 and `primed`=0.
